// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back wins, long-latency results queue and drain in idle slots.
// Optional starvation guard (stall_req pulse) enabled by defining WB_ARB_STARVE_EN.
module wb_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_rd,
  input  logic [DATA_W-1:0] pipe_wd,
  input  logic              mc_valid,
  input  logic [ADDR_W-1:0] mc_rd,
  input  logic [DATA_W-1:0] mc_wd,
  output logic              mc_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              stall_req
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_cfg
    $error("wb_port_arbiter: FIFO_DEPTH must be a power of 2 >= 2 and STARVE_LIMIT >= 1");
  end

  logic [FIFO_DEPTH-1:0]             ent_vld_q, ent_vld_d;
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0] ent_rd_q, ent_rd_d;
  logic [FIFO_DEPTH-1:0][DATA_W-1:0] ent_wd_q, ent_wd_d;
  logic [PTR_W-1:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic                              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]                 rf_wa_q, rf_wa_d;
  logic [DATA_W-1:0]                 rf_wd_q, rf_wd_d;
  logic                              stall_req_q, stall_req_d;

  logic pipe_hit, mc_hit, empty, full, push, pop, bypass;

  assign pipe_hit = pipe_we && (pipe_rd != '0);
  assign mc_hit   = mc_valid && (mc_rd != '0);
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign mc_ready = !full;

  always_comb begin
    ent_vld_d = ent_vld_q;
    ent_rd_d  = ent_rd_q;
    ent_wd_d  = ent_wd_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    rf_we_d   = 1'b0;
    rf_wa_d   = rf_wa_q;
    rf_wd_d   = rf_wd_q;
    pop       = 1'b0;
    bypass    = 1'b0;
    if (pipe_hit) begin
      rf_we_d = 1'b1;
      rf_wa_d = pipe_rd;
      rf_wd_d = pipe_wd;
      // Queued results to the same register are older than this write.
      for (int i = 0; i < FIFO_DEPTH; i++)
        if (ent_rd_q[i] == pipe_rd) ent_vld_d[i] = 1'b0;
    end else if (!empty) begin
      pop = 1'b1;
      if (ent_vld_q[rd_ptr_q]) begin
        rf_we_d = 1'b1;
        rf_wa_d = ent_rd_q[rd_ptr_q];
        rf_wd_d = ent_wd_q[rd_ptr_q];
      end
    end else if (mc_hit) begin
      bypass  = 1'b1;
      rf_we_d = 1'b1;
      rf_wa_d = mc_rd;
      rf_wd_d = mc_wd;
    end
    push = mc_hit && !full && !bypass;
    if (push) begin
      ent_vld_d[wr_ptr_q] = 1'b1;
      ent_rd_d[wr_ptr_q]  = mc_rd;
      ent_wd_d[wr_ptr_q]  = mc_wd;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
  end

`ifdef WB_ARB_STARVE_EN
  localparam int AGE_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FORCE} state_e;
  state_e           state_q, state_d;
  logic [AGE_W-1:0] age_q, age_d;

  always_comb begin
    state_d = state_q;
    age_d   = age_q;
    case (state_q)
      S_IDLE: if (cnt_d != '0) begin
        state_d = S_WAIT;
        age_d   = '0;
      end
      S_WAIT: begin
        if (cnt_d == '0) begin
          state_d = S_IDLE;
          age_d   = '0;
        end else if (pop) begin
          age_d = '0;
        end else if (age_q == AGE_W'(STARVE_LIMIT - 1)) begin
          state_d = S_FORCE;
          age_d   = '0;
        end else begin
          age_d = age_q + AGE_W'(1);
        end
      end
      S_FORCE: begin
        age_d   = '0;
        state_d = (cnt_d != '0) ? S_WAIT : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        age_d   = '0;
      end
    endcase
    stall_req_d = (state_d == S_FORCE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
    end
  end
`else
  assign stall_req_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_vld_q   <= '0;
      ent_rd_q    <= '0;
      ent_wd_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rf_we_q     <= 1'b0;
      rf_wa_q     <= '0;
      rf_wd_q     <= '0;
      stall_req_q <= 1'b0;
    end else begin
      ent_vld_q   <= ent_vld_d;
      ent_rd_q    <= ent_rd_d;
      ent_wd_q    <= ent_wd_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rf_we_q     <= rf_we_d;
      rf_wa_q     <= rf_wa_d;
      rf_wd_q     <= rf_wd_d;
      stall_req_q <= stall_req_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_wa     = rf_wa_q;
  assign rf_wd     = rf_wd_q;
  assign stall_req = stall_req_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: expected register-file writes are queued at issue
// and a negedge monitor checks every rf_we pulse against the queue.
module tb_wb_port_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_rd;
  logic [DATA_W-1:0] pipe_wd;
  logic              mc_valid;
  logic [ADDR_W-1:0] mc_rd;
  logic [DATA_W-1:0] mc_wd;
  logic              mc_ready;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_wa;
  logic [DATA_W-1:0] rf_wd;
  logic              stall_req;

  wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(2), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd),
    .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_wd(mc_wd), .mc_ready(mc_ready),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe_issue(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] wd);
    pipe_we = 1'b1;
    pipe_rd = rd;
    pipe_wd = wd;
    exp_q.push_back('{wa: rd, wd: wd});
  endtask

  task automatic mc_issue(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] wd);
    mc_valid = 1'b1;
    mc_rd    = rd;
    mc_wd    = wd;
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] wd);
    exp_q.push_back('{wa: rd, wd: wd});
  endtask

  // Monitor: every write the DUT presents must be the next expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got wa=%0d wd=%0h, expected no write", rf_wa, rf_wd);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(rf_wa), 64'(e.wa));
        chk("wr_data", 64'(rf_wd), 64'(e.wd));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic exp_stall;
    rst_n = 1'b0; pipe_we = 1'b0; pipe_rd = '0; pipe_wd = '0;
    mc_valid = 1'b0; mc_rd = '0; mc_wd = '0;
    repeat (2) @(negedge clk);
    chk("reset_rf_we", 64'(rf_we), 64'd0);
    chk("reset_rf_wa", 64'(rf_wa), 64'd0);
    chk("reset_rf_wd", 64'(rf_wd), 64'd0);
    chk("reset_stall", 64'(stall_req), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    chk("reset_mc_ready", 64'(mc_ready), 64'd1);

    // Reset mid-drain: two queued results must vanish.
    pipe_issue(5'd1, 32'h100); mc_issue(5'd10, 32'hA); step();
    pipe_issue(5'd2, 32'h200); mc_issue(5'd11, 32'hB); step();
    chk("full_before_reset", 64'(mc_ready), 64'd0);
    @(negedge clk); #1;
    rst_n = 1'b0; pipe_we = 1'b0; mc_valid = 1'b0;
    @(negedge clk);
    chk("midreset_rf_we", 64'(rf_we), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    chk("postreset_mc_ready", 64'(mc_ready), 64'd1);
    repeat (4) step();

    // Pipe only.
    pipe_issue(5'd5, 32'hDEADBEEF); step();
    pipe_we = 1'b0; step();

    // Bypass: FIFO stays empty, so nothing follows.
    mc_issue(5'd7, 32'h12); step();
    mc_valid = 1'b0;
    expect_wr(5'd7, 32'h12);
    chk("bypass_mc_ready", 64'(mc_ready), 64'd1);
    repeat (3) step();

    // Queue and full.
    pipe_issue(5'd20, 32'h20); mc_issue(5'd3, 32'h33); step();
    pipe_issue(5'd21, 32'h21); mc_issue(5'd4, 32'h44); step();
    chk("full_mc_ready", 64'(mc_ready), 64'd0);
    pipe_issue(5'd22, 32'h22); mc_valid = 1'b0; step();
    pipe_issue(5'd23, 32'h23); step();
    chk("still_full", 64'(mc_ready), 64'd0);
    pipe_we = 1'b0;
    expect_wr(5'd3, 32'h33);
    expect_wr(5'd4, 32'h44);
    step();
    chk("drain_mc_ready", 64'(mc_ready), 64'd1);
    repeat (3) step();

    // WAW kill: queued rd=9 is older than the pipeline write.
    pipe_issue(5'd1, 32'h55); mc_issue(5'd9, 32'h1); step();
    pipe_issue(5'd9, 32'h2); mc_valid = 1'b0; step();
    pipe_we = 1'b0; step();
    chk("waw_no_write", 64'(rf_we), 64'd0);
    chk("waw_hold_wa", 64'(rf_wa), 64'd9);
    chk("waw_hold_wd", 64'(rf_wd), 64'h2);
    repeat (3) step();

    // rd==0 requests are no requests.
    pipe_we = 1'b1; pipe_rd = 5'd0; pipe_wd = 32'hBAD0; mc_issue(5'd0, 32'hBAD1); step();
    chk("rd0_no_write", 64'(rf_we), 64'd0);
    chk("rd0_hold_wa", 64'(rf_wa), 64'd9);
    pipe_issue(5'd6, 32'h66); mc_issue(5'd0, 32'h77); step();
    pipe_we = 1'b0; mc_valid = 1'b0;
    chk("rd0_not_queued", 64'(mc_ready), 64'd1);
    repeat (3) step();

    // Starvation: pipe busy forever with one entry queued.
    pipe_issue(5'd1, 32'h600); mc_issue(5'd12, 32'hC); step();
    mc_valid = 1'b0;
    chk("starve_start", 64'(stall_req), 64'd0);
    for (int i = 1; i <= 10; i++) begin
      pipe_issue(5'(1 + (i % 8)), 32'h600 + 32'(i));
      step();
`ifdef WB_ARB_STARVE_EN
      exp_stall = (i == 8);
`else
      exp_stall = 1'b0;
`endif
      chk($sformatf("stall_req_c%0d", i), 64'(stall_req), 64'(exp_stall));
    end
    pipe_we = 1'b0;
    expect_wr(5'd12, 32'hC);
    repeat (4) step();
    chk("starve_stall_clear", 64'(stall_req), 64'd0);

    chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
